// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg: shared constants, scoreboard entry type and match helper.
// Entry dst is stored at ADDR_MAX bits so the struct stays unparameterised.
package pipe_hazard_ctrl_pkg;
    localparam int FWD_REGFILE = 0;
    localparam int STG_EXE     = 1;
    localparam int STG_MEM     = 2;
    localparam int ADDR_MAX    = 8;

    typedef struct packed {
        logic [ADDR_MAX-1:0] dst;
        logic                wen;
        logic                load;
    } sb_entry_t;

    function automatic logic sb_hit(sb_entry_t e, logic [ADDR_MAX-1:0] src, logic used);
        return used && e.wen && (e.dst != '0) && (e.dst == src);
    endfunction
endpackage

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: in-flight write shift register with youngest-first match,
// producing forwarding selects, store-data forward and load-use stall.
module hazard_scoreboard
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 1,
    parameter int ADDR_W   = 5,
    parameter int SEL_W    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold_i,
    input  logic              push_i,
    input  sb_entry_t         push_e_i,
    input  logic [ADDR_W-1:0] rs_i,
    input  logic [ADDR_W-1:0] rt_i,
    input  logic              rs_used_i,
    input  logic              rt_used_i,
    input  logic              is_store_i,
    output logic [SEL_W-1:0]  fwd_a_sel_o,
    output logic [SEL_W-1:0]  fwd_b_sel_o,
    output logic              fwd_m_o,
    output logic              load_stall_o
);
    sb_entry_t sb_q [1:DEPTH];
    logic hit_a, hit_b, ld_a, ld_b, stall_a, stall_b, m_ok;
    logic [SEL_W-1:0] idx_a, idx_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 1; k <= DEPTH; k++) sb_q[k] <= '0;
        end else if (!hold_i) begin
            sb_q[1] <= push_i ? push_e_i : '0;
            for (int k = 2; k <= DEPTH; k++) sb_q[k] <= sb_q[k-1];
        end
    end

    // Scan oldest to youngest so the youngest match is the one left standing.
    always_comb begin
        hit_a = 1'b0;
        ld_a  = 1'b0;
        idx_a = '0;
        hit_b = 1'b0;
        ld_b  = 1'b0;
        idx_b = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (sb_hit(sb_q[k], ADDR_MAX'(rs_i), rs_used_i)) begin
                hit_a = 1'b1;
                ld_a  = sb_q[k].load;
                idx_a = SEL_W'(k);
            end
            if (sb_hit(sb_q[k], ADDR_MAX'(rt_i), rt_used_i)) begin
                hit_b = 1'b1;
                ld_b  = sb_q[k].load;
                idx_b = SEL_W'(k);
            end
        end
    end

    assign stall_a = hit_a && ld_a && (idx_a <= SEL_W'(LOAD_LAT));
    assign stall_b = hit_b && ld_b && (idx_b <= SEL_W'(LOAD_LAT));
    // Store data can be picked up at the MEM write port when only rt waits on the load.
    assign m_ok = is_store_i && stall_b && (idx_b == SEL_W'(LOAD_LAT)) && !(hit_a && idx_a == idx_b);
    assign load_stall_o = stall_a || (stall_b && !m_ok);
    assign fwd_m_o      = m_ok && !load_stall_o;
    assign fwd_a_sel_o  = (hit_a && !stall_a) ? idx_a : SEL_W'(FWD_REGFILE);
    assign fwd_b_sel_o  = (hit_b && !stall_b) ? idx_b : SEL_W'(FWD_REGFILE);
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard, forwarding and stage-control unit for a DEPTH-stage back end.
// Optional single-step debug hold under PIPE_HAZARD_DEBUG_STEP_EN.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 1,
    parameter int ADDR_W   = 5,
    parameter int SEL_W    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
`ifdef PIPE_HAZARD_DEBUG_STEP_EN
    input  logic              debug_en,
    input  logic              debug_step,
`endif
    input  logic              id_valid,
    input  logic [ADDR_W-1:0] id_rs,
    input  logic [ADDR_W-1:0] id_rt,
    input  logic              id_rs_used,
    input  logic              id_rt_used,
    input  logic [ADDR_W-1:0] id_dst,
    input  logic              id_wen,
    input  logic              id_is_load,
    input  logic              id_is_store,
    input  logic              jump_en,
    input  logic              rom_stall,
    input  logic              ram_stall,
    output logic [SEL_W-1:0]  fwd_a_sel,
    output logic [SEL_W-1:0]  fwd_b_sel,
    output logic              fwd_m,
    output logic              load_stall,
    output logic              if_en,
    output logic              if_rst,
    output logic              id_en,
    output logic              id_rst,
    output logic [DEPTH-1:0]  bk_en,
    output logic [DEPTH-1:0]  bk_rst,
    output logic [31:0]       stall_cnt
);
    logic dbg_hold, hold, push, sb_fwd_m, sb_stall;
    logic [SEL_W-1:0] sb_a, sb_b;
    logic [31:0] stall_cnt_q;
    sb_entry_t push_e;

`ifdef PIPE_HAZARD_DEBUG_STEP_EN
    logic debug_step_prev_q;
    always_ff @(posedge clk) debug_step_prev_q <= rst ? 1'b0 : debug_step;
    assign dbg_hold = debug_en && !(debug_step && !debug_step_prev_q);
`else
    assign dbg_hold = 1'b0;
`endif

    assign hold   = ram_stall || dbg_hold;
    assign push   = id_valid && !rom_stall && !load_stall;
    assign push_e = '{dst: ADDR_MAX'(id_dst), wen: id_wen, load: id_is_load};

    hazard_scoreboard #(
        .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .ADDR_W(ADDR_W), .SEL_W(SEL_W)
    ) u_sb (
        .clk(clk), .rst(rst), .hold_i(hold), .push_i(push), .push_e_i(push_e),
        .rs_i(id_rs), .rt_i(id_rt), .rs_used_i(id_rs_used), .rt_used_i(id_rt_used),
        .is_store_i(id_is_store), .fwd_a_sel_o(sb_a), .fwd_b_sel_o(sb_b),
        .fwd_m_o(sb_fwd_m), .load_stall_o(sb_stall)
    );

    assign fwd_a_sel  = rst ? '0 : sb_a;
    assign fwd_b_sel  = rst ? '0 : sb_b;
    assign fwd_m      = sb_fwd_m && !rst;
    assign load_stall = sb_stall && !rst;

    // A jump is only honoured on a cycle with no stall; ID presents it again afterwards.
    always_comb begin
        if_en  = 1'b1;
        id_en  = 1'b1;
        bk_en  = '1;
        if_rst = 1'b0;
        id_rst = 1'b0;
        bk_rst = '0;
        if (rst) begin
            if_rst = 1'b1;
            id_rst = 1'b1;
            bk_rst = '1;
        end else if (hold) begin
            if_en = 1'b0;
            id_en = 1'b0;
            bk_en = '0;
        end else if (rom_stall || load_stall) begin
            if_en = 1'b0;
            id_en = 1'b0;
            bk_rst[STG_EXE-1] = 1'b1;
        end else if (jump_en) begin
            id_rst = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) stall_cnt_q <= '0;
        else if (ram_stall || rom_stall || load_stall) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
    assign stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed scoreboard bench for pipe_hazard_ctrl (DEPTH=3, LOAD_LAT=1).
module tb_pipe_hazard_ctrl;
    logic clk, rst, id_valid, id_rs_used, id_rt_used, id_wen, id_is_load, id_is_store;
    logic jump_en, rom_stall, ram_stall, fwd_m, load_stall, if_en, if_rst, id_en, id_rst;
    logic [4:0] id_rs, id_rt, id_dst;
    logic [1:0] fwd_a_sel, fwd_b_sel;
    logic [2:0] bk_en, bk_rst;
    logic [31:0] stall_cnt;

    typedef struct {
        string       tag;
        logic [5:0]  fwd;
        logic [9:0]  ctl;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int n_chk = 0;
    int n_fail = 0;

    // {if_en, if_rst, id_en, id_rst, bk_en, bk_rst}
    localparam logic [9:0] RUN = 10'b1010_111_000;
    localparam logic [9:0] STL = 10'b0000_111_001;
    localparam logic [9:0] RAM = 10'b0000_000_000;
    localparam logic [9:0] RST = 10'b1111_111_111;
    localparam logic [9:0] JMP = 10'b1011_111_000;

    pipe_hazard_ctrl dut (
        .clk(clk), .rst(rst),
`ifdef PIPE_HAZARD_DEBUG_STEP_EN
        .debug_en(1'b0), .debug_step(1'b0),
`endif
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_dst(id_dst),
        .id_wen(id_wen), .id_is_load(id_is_load), .id_is_store(id_is_store),
        .jump_en(jump_en), .rom_stall(rom_stall), .ram_stall(ram_stall),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .fwd_m(fwd_m),
        .load_stall(load_stall), .if_en(if_en), .if_rst(if_rst), .id_en(id_en),
        .id_rst(id_rst), .bk_en(bk_en), .bk_rst(bk_rst), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        rst = 1'b0; id_valid = 1'b0; id_rs = '0; id_rt = '0; id_rs_used = 1'b0;
        id_rt_used = 1'b0; id_dst = '0; id_wen = 1'b0; id_is_load = 1'b0;
        id_is_store = 1'b0; jump_en = 1'b0; rom_stall = 1'b0; ram_stall = 1'b0;
    endtask

    task automatic dec(input logic [4:0] rs, input logic rsu, input logic [4:0] rt,
                       input logic rtu, input logic [4:0] dst, input logic wen,
                       input logic ld, input logic st);
        id_valid = 1'b1; id_rs = rs; id_rs_used = rsu; id_rt = rt; id_rt_used = rtu;
        id_dst = dst; id_wen = wen; id_is_load = ld; id_is_store = st;
    endtask

    task automatic cyc(input string tag, input logic [1:0] a, input logic [1:0] b,
                       input logic m, input logic ls, input logic [9:0] ctl,
                       input logic [31:0] cnt);
        exp_t e;
        e.tag = tag;
        e.fwd = {a, b, m, ls};
        e.ctl = ctl;
        e.cnt = cnt;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        #2;
        if (exp_q.size() != 0) begin
            cur = exp_q.pop_front();
            chk({cur.tag, "/fwd"}, 32'({fwd_a_sel, fwd_b_sel, fwd_m, load_stall}), 32'(cur.fwd));
            chk({cur.tag, "/ctl"}, 32'({if_en, if_rst, id_en, id_rst, bk_en, bk_rst}), 32'(cur.ctl));
            chk({cur.tag, "/cnt"}, stall_cnt, cur.cnt);
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        idle(); rst = 1'b1;
        @(negedge clk);
        rst = 1'b1;                             cyc("reset", 0, 0, 0, 0, RST, 0);
        idle(); dec(1, 1, 2, 1, 3, 1, 0, 0);    cyc("add_r3", 0, 0, 0, 0, RUN, 0);
        idle(); dec(3, 1, 0, 0, 0, 0, 0, 0);    cyc("fwd_e1", 1, 0, 0, 0, RUN, 0);
        idle(); dec(3, 1, 0, 0, 0, 0, 0, 0);    cyc("fwd_e2", 2, 0, 0, 0, RUN, 0);
        idle(); dec(3, 1, 0, 0, 0, 0, 0, 0);    cyc("fwd_e3", 3, 0, 0, 0, RUN, 0);
        idle(); dec(0, 0, 0, 0, 4, 1, 1, 0);    cyc("lw_r4", 0, 0, 0, 0, RUN, 0);
        idle(); dec(1, 1, 4, 1, 7, 1, 0, 0);    cyc("ld_use", 0, 0, 0, 1, STL, 0);
        idle(); dec(1, 1, 4, 1, 7, 1, 0, 0);    cyc("ld_fwd2", 0, 2, 0, 0, RUN, 1);
        idle(); dec(1, 1, 0, 0, 5, 1, 1, 0);    cyc("lw_r5", 0, 0, 0, 0, RUN, 1);
        idle(); dec(0, 1, 5, 1, 0, 0, 0, 1);    cyc("sw_fwd_m", 0, 0, 1, 0, RUN, 1);
        idle(); dec(1, 1, 2, 1, 6, 1, 0, 0);    cyc("add_r6a", 0, 0, 0, 0, RUN, 1);
        idle(); dec(5, 1, 0, 0, 6, 1, 0, 0);    cyc("ld_fwd3", 3, 0, 0, 0, RUN, 1);
        idle(); dec(6, 1, 6, 1, 0, 1, 0, 0);    cyc("youngest", 1, 1, 0, 0, RUN, 1);
        idle(); dec(0, 1, 6, 1, 0, 0, 0, 0);    cyc("r0_nofwd", 0, 2, 0, 0, RUN, 1);
        for (int i = 0; i < 3; i++) begin
            idle(); dec(0, 1, 6, 1, 9, 1, 0, 0); ram_stall = 1'b1;
            cyc("ram_stall", 0, 3, 0, 0, RAM, 32'(1 + i));
        end
        idle(); dec(0, 1, 6, 1, 9, 1, 0, 0);    cyc("ram_hold", 0, 3, 0, 0, RUN, 4);
        idle(); dec(0, 0, 0, 0, 0, 0, 0, 0); jump_en = 1'b1;
                                                cyc("jump", 0, 0, 0, 0, JMP, 4);
        idle(); dec(0, 0, 0, 0, 8, 1, 1, 0);    cyc("lw_r8", 0, 0, 0, 0, RUN, 4);
        idle(); dec(8, 1, 0, 0, 0, 0, 0, 0); jump_en = 1'b1;
                                                cyc("jmp_in_stall", 0, 0, 0, 1, STL, 4);
        idle(); dec(8, 1, 0, 0, 0, 0, 0, 0); jump_en = 1'b1;
                                                cyc("jmp_after", 2, 0, 0, 0, JMP, 5);
        idle(); dec(0, 0, 0, 0, 4, 1, 1, 0);    cyc("lw_r4b", 0, 0, 0, 0, RUN, 5);
        idle(); dec(4, 1, 0, 0, 0, 0, 0, 0); rst = 1'b1;
                                                cyc("rst_in_stall", 0, 0, 0, 0, RST, 5);
        idle(); dec(4, 1, 0, 0, 0, 0, 0, 0);    cyc("post_rst", 0, 0, 0, 0, RUN, 0);
        idle(); rom_stall = 1'b1;               cyc("rom_stall", 0, 0, 0, 0, STL, 0);
        idle(); rom_stall = 1'b1; ram_stall = 1'b1;
                                                cyc("ram_over_rom", 0, 0, 0, 0, RAM, 1);
        idle();                                 cyc("idle", 0, 0, 0, 0, RUN, 2);
        idle();
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) chk("drain", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Parametrised hazard, forwarding and stage-control unit for the MIPS in-order pipeline, generalised to DEPTH back-end stages and configurable load latency. It owns an internal scoreboard of in-flight writes, so it no longer relies on per-stage feedback. It produces per-operand forwarding selects, load-use and memory-stall handling, and IF/ID/back-end enables and resets.

Parameters:
DEPTH, 3, back-end stages after ID (1=EXE ... DEPTH=WB); legal range 2..6
LOAD_LAT, 1, stages after EXE before load data exists on a stage result bus; must be < DEPTH
ADDR_W, 5, register address width
SEL_W, $clog2(DEPTH+1), forwarding select width (derived)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
id_valid  in  1  ID holds a real instruction
id_rs, id_rt  in  ADDR_W  source addresses
id_rs_used, id_rt_used  in  1  source actually read
id_dst  in  ADDR_W  resolved write address
id_wen, id_is_load, id_is_store  in  1  decode flags
jump_en  in  1  ID redirects PC
rom_stall, ram_stall  in  1  instruction / data memory not ready
fwd_a_sel, fwd_b_sel  out  SEL_W  0=regfile, i=stage-i result bus
fwd_m  out  1  store data forwarded from load at MEM write port
load_stall  out  1  load-use stall this cycle
if_en, if_rst, id_en, id_rst  out  1  front-end control
bk_en, bk_rst  out  DEPTH  back-end stage controls, bit i-1 = stage i
stall_cnt  out  32  stalled-cycle performance counter

Behaviour:
- Scoreboard: entries 1..DEPTH of {dst, wen, load}. All cleared on rst.
- Scoreboard update per clk: ram_stall holds all entries. Otherwise entry i+1 <= entry i. Entry 1 <= ID decode when ID advances with id_valid; else it becomes empty (wen=0).
- Match: entry i matches a source when wen=1, dst!=0, dst==source, and that source is used. The youngest (smallest i) match wins. No match gives sel=0.
- Non-load match: sel=i, no stall.
- Load match with i>LOAD_LAT: sel=i.
- Load match with i<=LOAD_LAT: load_stall=1.
  - Exception: rt-only dependence, id_is_store=1 and i==LOAD_LAT: fwd_m=1, fwd_b_sel=0, no stall.
- Forwarding and load_stall outputs are combinational from scoreboard registers and ID inputs, with zero-cycle latency.
- Control priority, highest first:
  - rst: all *_rst=1.
  - ram_stall: all enables 0, nothing reset.
  - rom_stall: if_en=id_en=0, bk_rst[0]=1.
  - load_stall: if_en=id_en=0, bk_rst[0]=1.
  - jump_en: id_rst=1.
  - Otherwise: all enables 1, resets 0.
- Default state: enables 1, resets 0, except under the conditions above.
- jump_en during any stall is ignored that cycle. ID re-evaluates it after the stall clears.
- stall_cnt: reset 0. Increments when ram_stall | rom_stall | load_stall (and not rst). Wraps at 2^32-1 to 0.
- Reset values: fwd selects 0, fwd_m 0, load_stall 0, stall_cnt 0, all stage resets 1 while rst.
- Reset mid-stall: the scoreboard empties, so the first post-reset instruction never stalls.

Optional Feature:
Macro: PIPE_HAZARD_DEBUG_STEP_EN.
- With macro defined: adds inputs debug_en and debug_step.
  - A registered debug_step_prev detects a rising edge.
  - While debug_en=1 and no rising edge is present, all enables are 0 (priority just below rst) and the scoreboard holds.
  - A rising edge advances exactly one cycle.
- Without it: these ports and this logic are absent.

Decomposition:
- Shared package: forwarding select constant FWD_REGFILE=0, stage index constants, and scoreboard entry struct/typedef.
- Sub-module hazard_scoreboard: shift register, match logic and youngest-priority encoder.
- Top level keeps control priority and stall_cnt.

Test Plan:
- DEPTH=3: ADD r3 in entry 1, ID reads r3 as rs -> fwd_a_sel=1, no stall. Next cycle same read -> fwd_a_sel=2.
- LW r4 in entry 1 (LOAD_LAT=1), ID ADD uses r4 -> load_stall=1, if_en=id_en=0, bk_rst[0]=1 for one cycle. Next cycle fwd_sel=2.
- LW r5 in entry 1, ID SW with rt=r5, rs=r0 -> fwd_m=1, load_stall=0.
- Two writers to r6 in entries 1 and 2 -> sel=1. A write to r0 -> sel=0.
- ram_stall for 3 cycles mid-stream -> all enables 0, scoreboard unchanged, stall_cnt +3.
- rst asserted during load_stall -> next cycle load_stall=0, stall_cnt=0, all entries empty. jump_en with no stall -> id_rst=1 only.
